cache_control_nway: RTL

//  Control FSM for an N-way set-associative cache; successor of the 2-way cache_control.

---
 rtl/cache_control_nway_pkg.sv | 38 +++
 rtl/cache_control_nway_way_sel.sv | 46 ++++
 rtl/cache_control_nway.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cache_control_nway_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_pkg : controller state encoding and way-vector bit helpers (rev 1.0)
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int MAX_WAYS = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COMPARE   = 3'd1,
    S_WT_WRITE  = 3'd2,
    S_WRITEBACK = 3'd3,
    S_ALLOCATE  = 3'd4,
    S_ERROR     = 3'd5
  } cache_state_t;

  function automatic int popcount(input logic [MAX_WAYS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_WAYS; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Lowest set bit wins, so this also serves as a priority encoder.
  function automatic int onehot_to_idx(input logic [MAX_WAYS-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_control_nway_way_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_way_sel : hit qualification, multi-hit detect, victim choice (rev 1.0)
// ---------------------------------------------------------------------------
module cache_way_sel
  import cache_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-1:0]         i_hit_way,
  input  logic [WAYS-1:0]         i_is_valid,
  input  logic [WAYS-1:0]         i_is_dirty,
  input  logic [$clog2(WAYS)-1:0] i_lru_way,
  output logic                    o_hit,
  output logic                    o_multi_hit,
  output logic [$clog2(WAYS)-1:0] o_hit_idx,
  output logic [$clog2(WAYS)-1:0] o_victim_idx,
  output logic                    o_victim_dirty
);

  localparam int IW = $clog2(WAYS);

  logic [WAYS-1:0]     w_hv;
  logic [MAX_WAYS-1:0] w_hv_ext;
  logic [MAX_WAYS-1:0] w_inv_ext;
  logic                w_any_invalid;

  // A stale tag match on an invalid way must never count as a hit.
  assign w_hv          = i_hit_way & i_is_valid;
  assign w_any_invalid = ~&i_is_valid;

  always_comb begin
    w_hv_ext              = '0;
    w_inv_ext             = '0;
    w_hv_ext[WAYS-1:0]    = w_hv;
    w_inv_ext[WAYS-1:0]   = ~i_is_valid;
  end

  assign o_hit          = |w_hv;
  assign o_multi_hit    = popcount(w_hv_ext) > 1;
  assign o_hit_idx      = IW'(onehot_to_idx(w_hv_ext));
  assign o_victim_idx   = w_any_invalid ? IW'(onehot_to_idx(w_inv_ext)) : i_lru_way;
  assign o_victim_dirty = i_is_valid[o_victim_idx] & i_is_dirty[o_victim_idx];

endmodule
`default_nettype wire

// File: rtl/cache_control_nway.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_control_nway : N-way set-associative cache control FSM (rev 1.0)
// ---------------------------------------------------------------------------
module cache_control_nway
  import cache_pkg::*;
#(
  parameter int WAYS         = 4,
  parameter bit WRITE_BACK   = 1'b1,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [WAYS-1:0]         hit_way,
  input  logic [WAYS-1:0]         is_valid,
  input  logic [WAYS-1:0]         is_dirty,
  input  logic [$clog2(WAYS)-1:0] lru_way,
  input  logic                    ca_resp,
  output logic                    cpu_mem_valid,
  output logic [WAYS-1:0]         load_data,
  output logic [WAYS-1:0]         load_tag,
  output logic                    lru_load,
  output logic [$clog2(WAYS)-1:0] lru_touch,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    mem_addr_sel,
  output logic                    data_in_select,
  output logic [WAYS-1:0]         write_valid,
  output logic [WAYS-1:0]         set_valid,
  output logic [WAYS-1:0]         write_dirty,
  output logic [WAYS-1:0]         set_dirty,
  output logic                    error
);

  localparam int            IW         = $clog2(WAYS);
  localparam int            CW         = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] c_tmo_last = (RESP_TIMEOUT > 0) ? CW'(RESP_TIMEOUT - 1) : '0;

  cache_state_t  r_state;
  logic          r_is_write;
  logic [IW-1:0] r_victim_q;
  logic [CW-1:0] r_tmo;

  logic            w_hit;
  logic            w_multi_hit;
  logic [IW-1:0]   w_hit_idx;
  logic [IW-1:0]   w_victim_idx;
  logic            w_victim_dirty;
  logic [WAYS-1:0] w_hit_oh;
  logic [WAYS-1:0] w_victim_oh;
  logic            w_tmo_expire;

  cache_way_sel #(
    .WAYS (WAYS)
  ) u_way_sel (
    .i_hit_way      (hit_way),
    .i_is_valid     (is_valid),
    .i_is_dirty     (is_dirty),
    .i_lru_way      (lru_way),
    .o_hit          (w_hit),
    .o_multi_hit    (w_multi_hit),
    .o_hit_idx      (w_hit_idx),
    .o_victim_idx   (w_victim_idx),
    .o_victim_dirty (w_victim_dirty)
  );

  assign w_hit_oh    = WAYS'(1) << w_hit_idx;
  assign w_victim_oh = WAYS'(1) << r_victim_q;

  // A response arriving on the limit cycle takes priority over the timeout.
  assign w_tmo_expire = (RESP_TIMEOUT != 0) && (r_tmo == c_tmo_last) && !ca_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_victim_q <= '0;
      r_tmo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_read || cpu_write) begin
            r_state    <= S_COMPARE;
            r_is_write <= cpu_write;
          end
        end
        S_COMPARE: begin
          if (w_multi_hit) begin
            r_state <= S_ERROR;
          end else if (w_hit) begin
            if (r_is_write && !WRITE_BACK) begin
              r_state <= S_WT_WRITE;
              r_tmo   <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_victim_q <= w_victim_idx;
            r_tmo      <= '0;
            r_state    <= (WRITE_BACK && w_victim_dirty) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
        S_WT_WRITE, S_WRITEBACK, S_ALLOCATE: begin
          if (ca_resp) begin
            r_tmo <= '0;
            case (r_state)
              S_WT_WRITE:  r_state <= S_IDLE;
              S_WRITEBACK: r_state <= S_ALLOCATE;
              default:     r_state <= S_COMPARE;
            endcase
          end else if (w_tmo_expire) begin
            r_state <= S_ERROR;
          end else if (RESP_TIMEOUT != 0) begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_ERROR;
      endcase
    end
  end

  always_comb begin
    cpu_mem_valid  = 1'b0;
    load_data      = '0;
    load_tag       = '0;
    lru_load       = 1'b0;
    lru_touch      = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr_sel   = 1'b0;
    data_in_select = 1'b0;
    write_valid    = '0;
    set_valid      = '0;
    write_dirty    = '0;
    set_dirty      = '0;
    error          = 1'b0;
    case (r_state)
      S_COMPARE: begin
        if (!w_multi_hit && w_hit) begin
          lru_load  = 1'b1;
          lru_touch = w_hit_idx;
          if (r_is_write) begin
            load_data = w_hit_oh;
            if (WRITE_BACK) begin
              write_dirty   = w_hit_oh;
              set_dirty     = w_hit_oh;
              cpu_mem_valid = 1'b1;
            end
          end else begin
            cpu_mem_valid = 1'b1;
          end
        end
      end
      S_WT_WRITE: begin
        mem_write     = 1'b1;
        cpu_mem_valid = ca_resp;
      end
      S_WRITEBACK: begin
        mem_write    = 1'b1;
        mem_addr_sel = 1'b1;
        if (ca_resp) write_dirty = w_victim_oh;
      end
      S_ALLOCATE: begin
        mem_read = 1'b1;
        if (ca_resp) begin
          load_data      = w_victim_oh;
          load_tag       = w_victim_oh;
          data_in_select = 1'b1;
          write_valid    = w_victim_oh;
          set_valid      = w_victim_oh;
          write_dirty    = w_victim_oh;
        end
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire
